operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Pipeline stage between decode and execute in the pipelined CPU.
- Accepts a decoded instruction over a valid/ready handshake and drives the two read ports of the dual-read register memory.
- Captures the read data and forwards same-cycle and in-flight writeback data by snooping the memory write port.
- Presents the instruction plus both operands to execute over a second valid/ready handshake.
- Internal structure: two slots. Slot A is the read-in-flight slot; slot B is the output register.

Parameters:
DATA_W, 11, operand/register data width (matches memory data_in/data_out)
ADRS_W, 11, register address width (matches memory w_adrs/r_adrs)
OP_W, 5, opcode width carried through unchanged

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline kill (branch redirect)
in_valid  input  1  decode has an instruction
in_ready  output  1  stage accepts this cycle
in_opcode  input  OP_W  opcode
in_rd  input  ADRS_W  destination register, passed through
in_rs1  input  ADRS_W  source 1 address
in_rs2  input  ADRS_W  source 2 address
in_use_rs1  input  1  source 1 needed
in_use_rs2  input  1  source 2 needed
r_en1  output  1  memory read enable, port 1
r_adrs1  output  ADRS_W  memory read address, port 1
r_en2  output  1  memory read enable, port 2
r_adrs2  output  ADRS_W  memory read address, port 2
data_out1  input  DATA_W  memory read data, port 1 (valid cycle after r_en1)
data_out2  input  DATA_W  memory read data, port 2
wb_en  input  1  writeback write enable (same signal as memory w_en)
wb_adrs  input  ADRS_W  writeback address (memory w_adrs)
wb_data  input  DATA_W  writeback data (memory data_in)
out_valid  output  1  operands ready for execute
out_ready  input  1  execute accepts
out_opcode  output  OP_W  registered opcode
out_rd  output  ADRS_W  registered destination
out_op1  output  DATA_W  operand 1 (0 if unused)
out_op2  output  DATA_W  operand 2 (0 if unused)

Behaviour:

Memory and slot model
- Memory contract: registered read, data valid one cycle after r_en. A write and a read of the same address in the same cycle return old data; this stage corrects for that by forwarding.
- Reset (cycle with reset=1): A_valid=0, B_valid=0, fwd flags=0.
  - out_valid=0; out_opcode, out_rd, out_op1, out_op2 all 0.
  - in_ready=0; r_en1 and r_en2 forced 0.
- B_adv = !B_valid || out_ready.
- A_adv = A_valid && B_adv.
- in_ready = !reset && !flush && (!A_valid || A_adv).
- Accept = in_valid && in_ready.

Read-port drive (combinational)
- If A_valid && !A_adv (A stalled): r_enX = A.use_rsX, r_adrsX = A.rsX. This re-reads every stalled cycle.
- Else if accept: r_enX = in_use_rsX, r_adrsX = in_rsX.
- Else: r_enX = 0, r_adrsX = 0.

Forward register, per source X, updated every cycle that a read is issued
- fwdX_hit <= wb_en && r_enX && wb_adrs == r_adrsX.
- fwdX_data <= wb_data.

A to B transfer (cycle A_adv), per source X
- If !A.use_rsX: opX = 0.
- Else if wb_en && wb_adrs == A.rsX: opX = wb_data (current-cycle write, highest priority).
- Else if fwdX_hit: opX = fwdX_data.
- Else: opX = data_outX.
- B_valid <= 1.
- If out_ready && B_valid && !A_adv: B_valid <= 0.

B hold snoop
- While B_valid && !out_ready, each cycle with wb_en && wb_adrs == B.rsX && B.use_rsX: out_opX <= wb_data.

Latency and throughput
- Accept at cycle T -> out_valid at T+2 with no backpressure.
- Sustained 1 instruction/cycle.
- Backpressure holds both slots with no loss or duplication.

Flush
- At cycle t: A_valid, B_valid and fwd flags cleared at end of t; no accept in t.
- out_valid=0 from t+1.
- Flush has priority over out_ready and accept.
- Reset has priority over flush.

Hazards
- A RAW hazard against an instruction not yet at writeback is the upstream scoreboard's responsibility.
- This stage forwards from the writeback port only.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=0 during reset, 1 after; r_en1=r_en2=0 throughout; all out_* =0.
- Memory preloaded reg 0x045=0x1A4, reg 0x002=0x07F. Accept {op=3, rd=0x010, rs1=0x045, rs2=0x002, use both} at T, out_ready=1 -> r_en1=r_en2=1, r_adrs1=0x045, r_adrs2=0x002 at T. At T+2: out_valid=1, out_op1=0x1A4, out_op2=0x07F, out_rd=0x010.
- Same instruction with wb_en=1, wb_adrs=0x045, wb_data=0x2AA in acceptance cycle T -> out_op1=0x2AA (forward over stale memory data); out_op2=0x07F.
- out_ready=0 for 5 cycles with B and A full. Write 0x045<-0x111 at cycle 2 of the stall -> in_ready=0 throughout stall; B.op1 updates to 0x111; A re-reads each stall cycle. After release, A's op1 (rs1=0x045) = 0x111; no instruction lost or duplicated.
- Back-to-back 4 instructions, out_ready=1 -> out_valid high 4 consecutive cycles starting T+2, operands in order; in_use_rs2=0 on one -> its out_op2=0 and r_en2=0 on its issue cycle.
- Flush asserted with both slots full and in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle. Next accepted instruction appears 2 cycles after its accept; reset asserted mid-stall clears everything identically.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: decode -> execute pipeline stage.
// Slot A holds an instruction whose register reads are in flight; slot B is
// the output register. Writeback data is forwarded by snooping the memory
// write port, covering the read-during-write (old data) memory behaviour.
module operand_fetch #(
    parameter int DATA_W = 11,
    parameter int ADRS_W = 11,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [ADRS_W-1:0] in_rd,
    input  logic [ADRS_W-1:0] in_rs1,
    input  logic [ADRS_W-1:0] in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    output logic              r_en1,
    output logic [ADRS_W-1:0] r_adrs1,
    output logic              r_en2,
    output logic [ADRS_W-1:0] r_adrs2,
    input  logic [DATA_W-1:0] data_out1,
    input  logic [DATA_W-1:0] data_out2,
    input  logic              wb_en,
    input  logic [ADRS_W-1:0] wb_adrs,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [ADRS_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2
);

    // Slot A
    logic              a_valid;
    logic [OP_W-1:0]   a_opcode;
    logic [ADRS_W-1:0] a_rd;
    logic [ADRS_W-1:0] a_rs1;
    logic [ADRS_W-1:0] a_rs2;
    logic              a_use_rs1;
    logic              a_use_rs2;

    // Slot B source info, kept for the hold-time snoop
    logic [ADRS_W-1:0] b_rs1;
    logic [ADRS_W-1:0] b_rs2;
    logic              b_use_rs1;
    logic              b_use_rs2;

    // Writes that collided with the read issued last cycle
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;

    logic              b_adv;
    logic              a_adv;
    logic              accept;
    logic [DATA_W-1:0] op1_next;
    logic [DATA_W-1:0] op2_next;

    // Handshake and read-port drive; a stalled slot A re-reads every cycle
    always_comb begin
        b_adv    = !out_valid || out_ready;
        a_adv    = a_valid && b_adv;
        in_ready = !reset && !flush && (!a_valid || a_adv);
        accept   = in_valid && in_ready;
        r_en1    = 1'b0;
        r_en2    = 1'b0;
        r_adrs1  = '0;
        r_adrs2  = '0;
        if (!reset) begin
            if (a_valid && !a_adv) begin
                r_en1   = a_use_rs1;
                r_adrs1 = a_rs1;
                r_en2   = a_use_rs2;
                r_adrs2 = a_rs2;
            end else if (accept) begin
                r_en1   = in_use_rs1;
                r_adrs1 = in_rs1;
                r_en2   = in_use_rs2;
                r_adrs2 = in_rs2;
            end
        end
    end

    // Operand selection for the A->B transfer: live write, then forward, then memory
    always_comb begin
        if (!a_use_rs1)                         op1_next = '0;
        else if (wb_en && wb_adrs == a_rs1)     op1_next = wb_data;
        else if (fwd1_hit)                      op1_next = fwd1_data;
        else                                    op1_next = data_out1;

        if (!a_use_rs2)                         op2_next = '0;
        else if (wb_en && wb_adrs == a_rs2)     op2_next = wb_data;
        else if (fwd2_hit)                      op2_next = fwd2_data;
        else                                    op2_next = data_out2;
    end

    // Slot state, forward registers and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid    <= 1'b0;
            a_opcode   <= '0;
            a_rd       <= '0;
            a_rs1      <= '0;
            a_rs2      <= '0;
            a_use_rs1  <= 1'b0;
            a_use_rs2  <= 1'b0;
            b_rs1      <= '0;
            b_rs2      <= '0;
            b_use_rs1  <= 1'b0;
            b_use_rs2  <= 1'b0;
            fwd1_hit   <= 1'b0;
            fwd2_hit   <= 1'b0;
            fwd1_data  <= '0;
            fwd2_data  <= '0;
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_op1    <= '0;
            out_op2    <= '0;
        end else if (flush) begin
            a_valid   <= 1'b0;
            out_valid <= 1'b0;
            fwd1_hit  <= 1'b0;
            fwd2_hit  <= 1'b0;
        end else begin
            fwd1_hit  <= wb_en && r_en1 && (wb_adrs == r_adrs1);
            fwd2_hit  <= wb_en && r_en2 && (wb_adrs == r_adrs2);
            fwd1_data <= wb_data;
            fwd2_data <= wb_data;

            if (accept) begin
                a_valid   <= 1'b1;
                a_opcode  <= in_opcode;
                a_rd      <= in_rd;
                a_rs1     <= in_rs1;
                a_rs2     <= in_rs2;
                a_use_rs1 <= in_use_rs1;
                a_use_rs2 <= in_use_rs2;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end

            if (a_adv) begin
                out_valid  <= 1'b1;
                out_opcode <= a_opcode;
                out_rd     <= a_rd;
                out_op1    <= op1_next;
                out_op2    <= op2_next;
                b_rs1      <= a_rs1;
                b_rs2      <= a_rs2;
                b_use_rs1  <= a_use_rs1;
                b_use_rs2  <= a_use_rs2;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else if (out_valid) begin
                if (wb_en && b_use_rs1 && wb_adrs == b_rs1) out_op1 <= wb_data;
                if (wb_en && b_use_rs2 && wb_adrs == b_rs2) out_op2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read register memory model.
module tb_operand_fetch;

    localparam int DATA_W = 11;
    localparam int ADRS_W = 11;
    localparam int OP_W   = 5;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [ADRS_W-1:0] in_rd, in_rs1, in_rs2;
    logic              in_use_rs1, in_use_rs2;
    logic              r_en1, r_en2;
    logic [ADRS_W-1:0] r_adrs1, r_adrs2;
    logic [DATA_W-1:0] data_out1, data_out2;
    logic              wb_en;
    logic [ADRS_W-1:0] wb_adrs;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [OP_W-1:0]   out_opcode;
    logic [ADRS_W-1:0] out_rd;
    logic [DATA_W-1:0] out_op1, out_op2;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADRS_W)-1];

    operand_fetch #(.DATA_W(DATA_W), .ADRS_W(ADRS_W), .OP_W(OP_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .r_en1(r_en1), .r_adrs1(r_adrs1), .r_en2(r_en2), .r_adrs2(r_adrs2),
        .data_out1(data_out1), .data_out2(data_out2),
        .wb_en(wb_en), .wb_adrs(wb_adrs), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_op1(out_op1), .out_op2(out_op2)
    );

    always #5 clk = ~clk;

    // Registered-read memory: same-cycle read of a written address returns old data
    always @(posedge clk) begin
        if (wb_en) mem[wb_adrs] <= wb_data;
        if (r_en1) data_out1 <= mem[r_adrs1];
        if (r_en2) data_out2 <= mem[r_adrs2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [OP_W-1:0] op, input logic [ADRS_W-1:0] rd,
                          input logic [ADRS_W-1:0] rs1, input logic [ADRS_W-1:0] rs2,
                          input logic u1, input logic u2);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_use_rs1 = u1; in_use_rs2 = u2;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1;
        set_in(5'd1, 11'h001, 11'h045, 11'h002, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b exp 0", in_ready); else pass_cnt++;
            total_cnt++; if ({r_en1, r_en2} !== 2'b00) $display("FAIL rst_r_en: got %b exp 00", {r_en1, r_en2}); else pass_cnt++;
        end
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if ({out_opcode, out_rd, out_op1, out_op2} !== '0)
            $display("FAIL rst_out_fields: got %h/%h/%h/%h exp all 0", out_opcode, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b exp 1", in_ready); else pass_cnt++;
        // Preload registers through the write port
        wb_en = 1'b1; wb_adrs = 11'h045; wb_data = 11'h1A4;
        tick();
        wb_adrs = 11'h002; wb_data = 11'h07F;
        tick();
        wb_en = 1'b0;
        #1;
        total_cnt++; if ({r_en1, r_en2, out_valid} !== 3'b000)
            $display("FAIL idle_outputs: got r_en=%b%b out_valid=%b exp 000", r_en1, r_en2, out_valid); else pass_cnt++;
    endtask

    task automatic test_basic();
        tick();
        set_in(5'd3, 11'h010, 11'h045, 11'h002, 1'b1, 1'b1); in_valid = 1'b1;
        #1;
        total_cnt++; if ({in_ready, r_en1, r_en2} !== 3'b111) $display("FAIL basic_issue: got %b exp 111", {in_ready, r_en1, r_en2}); else pass_cnt++;
        total_cnt++; if (r_adrs1 !== 11'h045 || r_adrs2 !== 11'h002)
            $display("FAIL basic_adrs: got %h/%h exp 045/002", r_adrs1, r_adrs2); else pass_cnt++;
        tick(); in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_lat1: got %b exp 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, out_opcode, out_rd, out_op1, out_op2} !== {1'b1, 5'd3, 11'h010, 11'h1A4, 11'h07F})
            $display("FAIL basic_out: got v=%b op=%h rd=%h %h/%h exp 1 03 010 1a4/07f", out_valid, out_opcode, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_forward();
        // Write in the accept cycle: memory returns stale data, forward register fixes it
        set_in(5'd3, 11'h010, 11'h045, 11'h002, 1'b1, 1'b1); in_valid = 1'b1;
        wb_en = 1'b1; wb_adrs = 11'h045; wb_data = 11'h2AA;
        tick(); in_valid = 1'b0; wb_en = 1'b0;
        tick();
        total_cnt++; if ({out_valid, out_op1, out_op2} !== {1'b1, 11'h2AA, 11'h07F})
            $display("FAIL fwd_accept_cycle: got v=%b %h/%h exp 1 2aa/07f", out_valid, out_op1, out_op2); else pass_cnt++;
        tick();
        // Write in the A cycle: live writeback value wins
        set_in(5'd4, 11'h014, 11'h045, 11'h002, 1'b1, 1'b1); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        wb_en = 1'b1; wb_adrs = 11'h002; wb_data = 11'h033;
        tick(); wb_en = 1'b0;
        total_cnt++; if ({out_valid, out_rd, out_op1, out_op2} !== {1'b1, 11'h014, 11'h2AA, 11'h033})
            $display("FAIL fwd_live: got v=%b rd=%h %h/%h exp 1 014 2aa/033", out_valid, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_in(5'd1, 11'h011, 11'h045, 11'h002, 1'b1, 1'b1); in_valid = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_acc1: got %b exp 1", in_ready); else pass_cnt++;
        tick();
        set_in(5'd2, 11'h012, 11'h045, 11'h002, 1'b1, 1'b0);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_acc2: got %b exp 1", in_ready); else pass_cnt++;
        tick();
        set_in(5'd4, 11'h013, 11'h002, 11'h045, 1'b1, 1'b1);
        for (int s = 1; s <= 5; s++) begin
            if (s > 1) tick();
            wb_en = (s == 2); wb_adrs = 11'h045; wb_data = 11'h111;
            #1;
            total_cnt++; if ({in_ready, r_en1, r_en2} !== 3'b010 || r_adrs1 !== 11'h045)
                $display("FAIL stall_hold_%0d: got rdy=%b r_en=%b%b adrs=%h exp 0 10 045", s, in_ready, r_en1, r_en2, r_adrs1); else pass_cnt++;
            total_cnt++; if ({out_valid, out_rd, out_op1} !== {1'b1, 11'h011, (s >= 3) ? 11'h111 : 11'h2AA})
                $display("FAIL stall_b_%0d: got v=%b rd=%h op1=%h", s, out_valid, out_rd, out_op1); else pass_cnt++;
        end
        tick();
        wb_en = 1'b0; out_ready = 1'b1;
        #1;
        total_cnt++; if ({in_ready, out_rd} !== {1'b1, 11'h011}) $display("FAIL stall_release: got rdy=%b rd=%h exp 1 011", in_ready, out_rd); else pass_cnt++;
        tick(); in_valid = 1'b0;
        total_cnt++; if ({out_valid, out_opcode, out_rd, out_op1, out_op2} !== {1'b1, 5'd2, 11'h012, 11'h111, 11'h000})
            $display("FAIL stall_i2: got v=%b op=%h rd=%h %h/%h exp 1 02 012 111/000", out_valid, out_opcode, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, out_rd, out_op1, out_op2} !== {1'b1, 11'h013, 11'h033, 11'h111})
            $display("FAIL stall_i3: got v=%b rd=%h %h/%h exp 1 013 033/111", out_valid, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_drain: got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [ADRS_W-1:0] rs1 [4];
        logic [ADRS_W-1:0] rs2 [4];
        logic              u2  [4];
        logic [DATA_W-1:0] e1  [4];
        logic [DATA_W-1:0] e2  [4];
        rs1 = '{11'h045, 11'h002, 11'h045, 11'h002};
        rs2 = '{11'h002, 11'h045, 11'h002, 11'h002};
        u2  = '{1'b1, 1'b1, 1'b0, 1'b1};
        e1  = '{11'h111, 11'h033, 11'h111, 11'h033};
        e2  = '{11'h033, 11'h111, 11'h000, 11'h033};
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                set_in(5'(5 + c), 11'(32 + c), rs1[c], rs2[c], 1'b1, u2[c]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 4) begin
                total_cnt++; if ({in_ready, r_en2} !== {1'b1, u2[c]})
                    $display("FAIL b2b_issue_%0d: got rdy=%b r_en2=%b exp 1 %b", c, in_ready, r_en2, u2[c]); else pass_cnt++;
            end
            if (c >= 2 && c < 6) begin
                total_cnt++; if ({out_valid, out_rd, out_op1, out_op2} !== {1'b1, 11'(32 + c - 2), e1[c-2], e2[c-2]})
                    $display("FAIL b2b_out_%0d: got v=%b rd=%h %h/%h exp 1 %h %h/%h", c - 2, out_valid, out_rd, out_op1, out_op2, 11'(32 + c - 2), e1[c-2], e2[c-2]); else pass_cnt++;
            end else begin
                total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_idle_%0d: got %b exp 0", c, out_valid); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(5'd1, 11'h011, 11'h045, 11'h002, 1'b1, 1'b1); in_valid = 1'b1;
        tick();
        set_in(5'd2, 11'h012, 11'h045, 11'h002, 1'b1, 1'b1);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        set_in(5'd9, 11'h030, 11'h002, 11'h045, 1'b1, 1'b1);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b exp 0", in_ready); else pass_cnt++;
        tick(); flush = 1'b0;
        #1;
        total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_after: got v=%b rdy=%b exp 0 1", out_valid, in_ready); else pass_cnt++;
        tick(); in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_lat1: got %b exp 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, out_rd, out_op1, out_op2} !== {1'b1, 11'h030, 11'h033, 11'h111})
            $display("FAIL flush_next: got v=%b rd=%h %h/%h exp 1 030 033/111", out_valid, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        set_in(5'd1, 11'h011, 11'h045, 11'h002, 1'b1, 1'b1); in_valid = 1'b1;
        tick();
        set_in(5'd2, 11'h012, 11'h045, 11'h002, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        total_cnt++; if ({in_ready, r_en1, r_en2} !== 3'b000) $display("FAIL rst_stall_drive: got %b exp 000", {in_ready, r_en1, r_en2}); else pass_cnt++;
        tick(); reset = 1'b0; out_ready = 1'b1;
        set_in(5'd10, 11'h031, 11'h045, 11'h002, 1'b1, 1'b1);
        #1;
        total_cnt++; if ({out_valid, out_opcode, out_rd, out_op1, out_op2} !== '0 || in_ready !== 1'b1)
            $display("FAIL rst_stall_clear: got v=%b %h/%h/%h/%h rdy=%b exp all 0 rdy 1", out_valid, out_opcode, out_rd, out_op1, out_op2, in_ready); else pass_cnt++;
        tick(); in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_stall_lat1: got %b exp 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, out_rd, out_op1, out_op2} !== {1'b1, 11'h031, 11'h111, 11'h033})
            $display("FAIL rst_stall_next: got v=%b rd=%h %h/%h exp 1 031 111/033", out_valid, out_rd, out_op1, out_op2); else pass_cnt++;
        tick();
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_adrs = '0; wb_data = '0;
        set_in('0, '0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_forward();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
